// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: stage-state encoding
// used for decode/debug, and the occupancy-width helper.
package pipe_pkg;

    // Stage state as seen through {skid_valid, main_valid}.
    // 2'b10 (skid without main) is unreachable and is treated as a fault.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 2;

    // Bits needed to count 0 .. 2*depth held beats.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

    // Decode the two valid bits of a stage into its state.
    function automatic stage_state_e stage_state(input logic main_v, input logic skid_v);
        stage_state_e st;
        case ({skid_v, main_v})
            2'b00:   st = ST_EMPTY;
            2'b01:   st = ST_HALF;
            2'b11:   st = ST_FULL;
            default: st = ST_FULL;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// One elastic stage: main register plus skid register. All outputs come
// straight from flops; ready toward upstream is the inverse of skid valid,
// so no combinational path exists from o_ready to i_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_dat_q, main_dat_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

    logic             i_hs_s;
    logic             o_hs_s;
    logic [1:0]       state_raw_s;
    stage_state_e     state_s;

    assign i_hs_s      = i_valid & ~skid_v_q;
    assign o_hs_s      = main_v_q & o_ready;
    assign state_raw_s = {skid_v_q, main_v_q};
    assign state_s     = stage_state(main_v_q, skid_v_q);

    assign i_ready = ~skid_v_q;
    assign o_valid = main_v_q;
    assign o_data  = main_dat_q;

    // Next-state logic: data registers load only on the transitions that need them.
    always_comb begin
        main_v_d   = main_v_q;
        skid_v_d   = skid_v_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (state_raw_s == 2'b10) begin
            // Skid valid without main valid cannot arise; drop back to empty.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (i_hs_s) begin
                        main_v_d   = 1'b1;
                        main_dat_d = i_data;
                    end else begin
                        main_v_d = 1'b0;
                    end
                end
                ST_HALF: begin
                    if (i_hs_s && o_hs_s) begin
                        main_dat_d = i_data;
                    end else if (i_hs_s) begin
                        skid_v_d   = 1'b1;
                        skid_dat_d = i_data;
                    end else if (o_hs_s) begin
                        main_v_d = 1'b0;
                    end else begin
                        main_v_d = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (o_hs_s) begin
                        main_dat_d = skid_dat_q;
                        skid_v_d   = 1'b0;
                    end else begin
                        skid_v_d = 1'b1;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    // Stage registers with synchronous reset to empty and RESET_VALUE data.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            main_dat_q <= RESET_VALUE;
            skid_dat_q <= RESET_VALUE;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: a chain of DEPTH skid stages with a
// valid/ready handshake, synchronous flush and a registered occupancy count.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           out_ready,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_elastic: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_reg_elastic: WIDTH must be at least 1");
    end

    // Index k is the input side of stage k; index k+1 is its output side.
    logic             chain_valid_s [DEPTH+1];
    logic             chain_ready_s [DEPTH+1];
    logic [WIDTH-1:0] chain_data_s  [DEPTH+1];

    logic             in_hs_s;
    logic             out_hs_s;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign chain_valid_s[0]     = in_valid;
    assign chain_data_s[0]      = in_data;
    assign in_ready             = chain_ready_s[0];
    assign out_valid            = chain_valid_s[DEPTH];
    assign out_data             = chain_data_s[DEPTH];
    assign chain_ready_s[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_skid #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .i_valid (chain_valid_s[k]),
            .i_data  (chain_data_s[k]),
            .i_ready (chain_ready_s[k]),
            .o_valid (chain_valid_s[k+1]),
            .o_data  (chain_data_s[k+1]),
            .o_ready (chain_ready_s[k+1])
        );
    end

    assign in_hs_s   = in_valid & in_ready;
    assign out_hs_s  = out_valid & out_ready;
    assign occupancy = occ_q;

    // Occupancy next value: +1 per accepted beat, -1 per emitted beat, 0 on flush.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = {OCC_W{1'b0}};
        end else begin
            case ({in_hs_s, out_hs_s})
                2'b10:   occ_d = occ_q + OCC_W'(1'b1);
                2'b01:   occ_d = occ_q - OCC_W'(1'b1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Occupancy register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the processor's plain 8-bit reset/load register. Adds configurable width and depth, a valid/ready handshake, a registered skid buffer per stage, a synchronous flush and an occupancy count.
- Used between datapath sections, e.g. fetch-to-decode or ALU-to-writeback, when the core moves to pipelined or stallable operation.
- Full throughput of 1 beat per cycle. Every output is driven from a register; there is no combinational ready path from out_ready back to in_ready.

Parameters:
- WIDTH, 8: data width in bits, must be at least 1.
- DEPTH, 2: number of elastic stages in the chain. Must be at least 1; DEPTH=0 is illegal and the block fails elaboration.
- RESET_VALUE, 0: value loaded into every data register on reset, WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all valid state.
- in_valid  in  1  upstream beat present.
- in_data  in  WIDTH  upstream data.
- in_ready  out  1  block can accept; registered.
- out_valid  out  1  downstream beat present; registered.
- out_data  out  WIDTH  downstream data; registered.
- out_ready  in  1  downstream accepts.
- occupancy  out  $clog2(2*DEPTH+1)  number of beats currently held, range 0 to 2*DEPTH.

Behaviour:
- A handshake occurs when valid and ready are both 1 at a rising edge. This applies on both the input and output side.
- Upstream must hold in_valid and in_data stable until the beat is accepted. The block guarantees the same on its output.
- Per stage:
  - Registers: main (m_v, m_d) and skid (s_v, s_d).
  - Stage output: o_valid = m_v, o_data = m_d.
  - Stage ready toward upstream: i_ready = ~s_v.
- Stage states and transitions (i = input handshake, o = output handshake):
  - EMPTY (m_v=0, s_v=0):
    - i: go to HALF, m_d <= input.
  - HALF (m_v=1, s_v=0):
    - i and o: stay HALF, m_d <= input.
    - i only: go to FULL, s_d <= input.
    - o only: go to EMPTY.
    - neither: hold.
  - FULL (m_v=1, s_v=1): i is impossible because i_ready=0.
    - o: go to HALF, m_d <= s_d, s_v <= 0.
    - no o: hold.
- Chain wiring:
  - Stage k output feeds stage k+1 input.
  - Stage 0 takes in_valid/in_data and drives in_ready.
  - Stage DEPTH-1 drives out_valid/out_data and takes out_ready.
- Latency and capacity:
  - With out_ready held at 1, a beat accepted at edge n appears on out_valid/out_data after edge n+DEPTH-1. For DEPTH=1 this means the cycle after acceptance.
  - Back-to-back beats stream with no bubbles.
  - Capacity is 2*DEPTH beats. in_ready falls only when stage 0 is FULL.
- Ordering: beats leave in strict FIFO order. No beat is ever dropped or duplicated, except by flush or reset.
- occupancy:
  - Registered count, updated by +1 on an input handshake and -1 on an output handshake.
  - Both handshakes in one cycle leave it unchanged.
  - It always equals the sum of all m_v and s_v bits.
- flush:
  - At the edge, clears all m_v and s_v bits and sets occupancy to 0. Data registers keep their values.
  - An input or output handshake in a flush cycle is treated as completed and the beat is discarded. Upstream and downstream see a normal handshake.
  - The cycle after a flush shows in_ready=1 and out_valid=0.
- reset:
  - Clears all valid bits, sets every data register to RESET_VALUE, and sets occupancy to 0.
  - Output values after reset: in_ready=1, out_valid=0, out_data=RESET_VALUE, occupancy=0.
  - Reset has priority over flush and over any handshake.
  - A reset mid-stream discards all held beats.
- No X propagation: data registers load only when their stage transition requires it.

Decomposition:
- Shared package (pipe_pkg): localparams for occupancy width and a stage-state encoding (EMPTY, HALF, FULL) for assertions and debug.
- Sub-module pipe_stage_skid: one elastic stage with WIDTH and RESET_VALUE parameters and ports clk, reset, flush, i_valid, i_data, i_ready, o_valid, o_data, o_ready.
- The top level instantiates DEPTH stages in a generate loop and holds the occupancy counter.

Test Plan:
- Reset, WIDTH=8, DEPTH=2, RESET_VALUE=8'hA5 -> in_ready=1, out_valid=0, out_data=8'hA5, occupancy=0.
- Stream 8'h01..8'h10 with out_ready=1 -> first out_valid appears 2 cycles after the first accept, then 16 consecutive beats in order, occupancy never above 2.
- Hold out_ready=0, push beats 8'h11..8'h14 -> in_ready falls after the 4th accept, occupancy=4, out_data=8'h11. Releasing out_ready outputs 11, 12, 13, 14 with no loss.
- Random in_valid/out_ready at 50% for 1000 beats, DEPTH=3, WIDTH=16 -> scoreboard order matches, occupancy equals the model every cycle.
- Fill to occupancy=3, then flush with in_valid=1 and data 8'h55 -> next cycle out_valid=0, in_ready=1, occupancy=0, and 8'h55 never appears on the output.
- Assert reset while FULL and out_ready=1 -> next cycle all outputs at reset values; no beat emitted in the reset cycle is counted.
